// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared FSM state, command bundle and bound-check helper for ram_ctrl
package ram_ctrl_pkg;

    localparam int RAM_CTRL_FIELD_W = 32;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} ram_ctrl_state_e;

    typedef struct packed {
        logic                        write;
        logic [RAM_CTRL_FIELD_W-1:0] addr;
        logic [RAM_CTRL_FIELD_W-1:0] len;
    } ram_ctrl_cmd_t;

    // true when a burst of len+1 beats starting at addr stays below depth
    function automatic logic ram_ctrl_fits(input logic [31:0] addr, input logic [31:0] len,
                                           input logic [31:0] depth);
        return ({1'b0, addr} + {1'b0, len} + 33'd1) <= {1'b0, depth};
    endfunction

endpackage

// File: rtl/ram_if.sv
// ram_if: single-port RAM interface
//   ctrl modport: drives we/din/addr, samples dout (1-cycle read latency)
//   mem  modport: the RAM side, clocked by clk
interface ram_if #(
    parameter int AWID = 8,
    parameter int DWID = 16
) (
    input logic clk
);
    logic            we;
    logic [DWID-1:0] din;
    logic [DWID-1:0] dout;
    logic [AWID-1:0] addr;

    modport ctrl (output we, output din, output addr, input dout);
    modport mem  (input clk, input we, input din, input addr, output dout);
endinterface

// File: rtl/ram_ctrl_rbuf.sv
// ram_ctrl_rbuf: 2-entry read-data FIFO {data, last} with occupancy count
//   clk, rst                      clock, async active-high reset (empties buffer)
//   push, push_data, push_last    write one entry
//   pop                           drop head entry (caller only pops when count != 0)
//   head_data, head_last, count   head entry and occupancy
module ram_ctrl_rbuf #(
    parameter int DWID = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [DWID-1:0] push_data,
    input  logic            push_last,
    input  logic            pop,
    output logic [DWID-1:0] head_data,
    output logic            head_last,
    output logic [1:0]      count
);
    logic [1:0][DWID-1:0] data_q;
    logic [1:0]           last_q;
    logic                 wr_ptr;
    logic                 rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            last_q <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: burst initiator on the ctrl side of ram_if
//   cmd_*    one burst command (write/read, start addr, beats-1), accepted in IDLE
//   wdata_*  write beats streamed straight into the RAM while in WRITE
//   rdata_*  read beats out of a 2-entry buffer with valid/ready, rdata_last on final beat
//   busy     burst in progress; done one-cycle completion pulse
//   err      one-cycle pulse on rejected out-of-range command (RAM_CTRL_BOUND_CHK_EN), else 0
//   ram      ram_if.ctrl port (we/din/addr driven, dout sampled one cycle after issue)
// Optional feature macro: RAM_CTRL_BOUND_CHK_EN
module ram_ctrl #(
    parameter int DEPTH = 256,
    parameter int AWID  = 8,
    parameter int DWID  = 16,
    parameter int LWID  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AWID-1:0] cmd_addr,
    input  logic [LWID-1:0] cmd_len,
    input  logic            wdata_valid,
    output logic            wdata_ready,
    input  logic [DWID-1:0] wdata,
    output logic            rdata_valid,
    input  logic            rdata_ready,
    output logic [DWID-1:0] rdata,
    output logic            rdata_last,
    output logic            busy,
    output logic            done,
    output logic            err,
    ram_if.ctrl             ram
);
    import ram_ctrl_pkg::*;

    localparam logic [LWID:0]   CNT_ONE   = (LWID+1)'(1);
    localparam logic [AWID-1:0] ADDR_ONE  = AWID'(1);
    localparam logic [AWID-1:0] ADDR_LAST = AWID'(DEPTH-1);

    ram_ctrl_state_e state, state_nxt;
    ram_ctrl_cmd_t   cmd;
    logic            unused_cmd;
    logic [AWID-1:0] addr_q, addr_inc;
    logic [LWID:0]   cnt_q;
    logic            inflight_q, inflight_last_q, done_q, err_q;
    logic [1:0]      fifo_count;
    logic [DWID-1:0] head_data;
    logic            head_last;
    logic            accept, reject, wr_beat, issue, pop, last_beat, drain_exit;
    logic [2:0]      occ;

    assign cmd        = '{write: cmd_write, addr: RAM_CTRL_FIELD_W'(cmd_addr), len: RAM_CTRL_FIELD_W'(cmd_len)};
    assign unused_cmd = ^cmd;

    // wrap explicitly so non-power-of-two depths stay in range
    assign addr_inc   = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
    assign last_beat  = cnt_q == CNT_ONE;
    assign accept     = state == IDLE && cmd_valid;
    assign wr_beat    = state == WRITE && wdata_valid;
    assign pop        = rdata_valid && rdata_ready;
    // buffer slots claimed next cycle: stored + in flight - leaving now
    assign occ        = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue      = state == READ && occ < 3'd2;
    // leave DRAIN in the cycle the last entry is popped so done follows it directly
    assign drain_exit = state == DRAIN && !inflight_q &&
                        (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop));

`ifdef RAM_CTRL_BOUND_CHK_EN
    assign reject = accept && !ram_ctrl_fits(cmd.addr, cmd.len, 32'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= reject;
    end
`else
    assign reject = 1'b0;
    assign err_q  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !reject) state_nxt = cmd.write ? WRITE : READ;
            WRITE:   if (wr_beat && last_beat) state_nxt = IDLE;
            READ:    if (issue && last_beat) state_nxt = DRAIN;
            DRAIN:   if (drain_exit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q          <= '0;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= (wr_beat && last_beat) || drain_exit;
            inflight_q      <= issue;
            inflight_last_q <= issue && last_beat;
            if (accept) begin
                addr_q <= cmd.addr[AWID-1:0];
                cnt_q  <= (LWID+1)'(cmd.len[LWID-1:0]) + CNT_ONE;
            end else if (wr_beat || issue) begin
                addr_q <= addr_inc;
                cnt_q  <= cnt_q - CNT_ONE;
            end
        end
    end

    always_comb begin
        cmd_ready   = state == IDLE && !rst;
        wdata_ready = state == WRITE;
        busy        = state != IDLE;
        done        = done_q;
        err         = err_q;
        rdata_valid = fifo_count != 2'd0;
        rdata       = head_data;
        rdata_last  = head_last && rdata_valid;
        ram.we      = wr_beat;
        ram.din     = state == WRITE ? wdata : '0;
        ram.addr    = addr_q;
    end

    ram_ctrl_rbuf #(.DWID(DWID)) u_rbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (ram.dout),
        .push_last (inflight_last_q),
        .pop       (pop),
        .head_data (head_data),
        .head_last (head_last),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed self-checking bench for ram_ctrl with a behavioural 1-cycle-latency RAM
module tb_ram_ctrl;
    localparam int DEPTH = 256;
    localparam int AWID  = 8;
    localparam int DWID  = 16;
    localparam int LWID  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AWID-1:0] cmd_addr = '0;
    logic [LWID-1:0] cmd_len = '0;
    logic            wdata_valid = 1'b0;
    logic [DWID-1:0] wdata = '0;
    logic            rdata_ready = 1'b0;
    logic            cmd_ready, wdata_ready, rdata_valid, rdata_last, busy, done, err;
    logic [DWID-1:0] rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DWID-1:0] mem   [DEPTH] = '{default: '0};
    logic [DWID-1:0] model [DEPTH] = '{default: '0};

    always #5 clk = ~clk;

    ram_if #(.AWID(AWID), .DWID(DWID)) ram (.clk(clk));

    always @(posedge clk) begin
        if (ram.we)
            mem[ram.addr] <= ram.din;
        ram.dout <= mem[ram.addr];
    end

    ram_ctrl #(.DEPTH(DEPTH), .AWID(AWID), .DWID(DWID), .LWID(LWID)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .ram         (ram)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct packed {
        logic       cv;
        logic       cw;
        logic [7:0] ca;
        logic [7:0] cl;
        logic       wv;
        logic [15:0] wd;
        logic       rr;
        logic       e_cr;
        logic       e_busy;
        logic       e_done;
        logic       e_we;
        logic       chk_a;
        logic [7:0] e_addr;
        logic       e_rv;
        logic [15:0] e_rd;
        logic       e_last;
    } vec_t;

    vec_t vecs [16];

    task automatic wr_burst(input logic [7:0] a, input int n, input logic [15:0] base);
        logic [7:0] exp_a;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = 8'(n - 1); wdata_valid = 1'b0;
        #1;
        chk("wr.cmd_ready", cmd_ready, 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0; wdata_valid = 1'b1; wdata = base + 16'(i);
            #1;
            exp_a = 8'((int'(a) + i) % DEPTH);
            chk($sformatf("wr.we[%0d]", i), ram.we, 1);
            chk($sformatf("wr.addr[%0d]", i), ram.addr, exp_a);
            chk($sformatf("wr.din[%0d]", i), ram.din, base + 16'(i));
            model[exp_a] = base + 16'(i);
        end
        @(posedge clk); #1;
        wdata_valid = 1'b0;
        #1;
        chk("wr.done", done, 1);
        chk("wr.busy_end", busy, 0);
        chk("wr.we_end", ram.we, 0);
    endtask

    task automatic rd_burst(input logic [7:0] a, input int n, input bit toggle);
        int got, n_last, cyc;
        bit seen_done, prev_stall;
        logic [15:0] prev_data;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = 8'(n - 1); rdata_ready = 1'b0;
        #1;
        chk("rd.cmd_ready", cmd_ready, 1);
        got = 0; n_last = 0; cyc = 0; seen_done = 0; prev_stall = 0; prev_data = '0;
        while (!seen_done && cyc < 4 * n + 20) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            rdata_ready = toggle ? !rdata_ready : 1'b1;
            #1;
            chk("rd.we_low", ram.we, 0);
            chk("rd.fill_le2", 32'(dut.fifo_count > 2'd2), 0);
            if (prev_stall) begin
                chk("rd.hold_valid", rdata_valid, 1);
                chk("rd.hold_data", rdata, prev_data);
            end
            if (done)
                seen_done = 1;
            if (rdata_valid && rdata_ready) begin
                chk($sformatf("rd.data[%0d]", got), rdata, model[(int'(a) + got) % DEPTH]);
                chk($sformatf("rd.last[%0d]", got), rdata_last, 32'(got == n - 1));
                if (rdata_last)
                    n_last++;
                got++;
            end
            prev_stall = rdata_valid && !rdata_ready;
            prev_data  = rdata;
            cyc++;
        end
        chk("rd.beats", got, n);
        chk("rd.last_count", n_last, 1);
        chk("rd.done_seen", 32'(seen_done), 1);
        rdata_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1, 1, 8'h10, 3, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 8'h00, 0, 16'h0000, 0};
        vecs[1]  = '{0, 0, 8'h00, 0, 1, 16'h1111, 0, 0, 1, 0, 1, 1, 8'h10, 0, 16'h0000, 0};
        vecs[2]  = '{0, 0, 8'h00, 0, 1, 16'h2222, 0, 0, 1, 0, 1, 1, 8'h11, 0, 16'h0000, 0};
        vecs[3]  = '{0, 0, 8'h00, 0, 1, 16'h3333, 0, 0, 1, 0, 1, 1, 8'h12, 0, 16'h0000, 0};
        vecs[4]  = '{0, 0, 8'h00, 0, 1, 16'h4444, 0, 0, 1, 0, 1, 1, 8'h13, 0, 16'h0000, 0};
        vecs[5]  = '{0, 0, 8'h00, 0, 0, 16'h0000, 0, 1, 0, 1, 0, 0, 8'h00, 0, 16'h0000, 0};
        vecs[6]  = '{0, 0, 8'h00, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 8'h00, 0, 16'h0000, 0};
        vecs[7]  = '{1, 0, 8'h10, 3, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 8'h00, 0, 16'h0000, 0};
        vecs[8]  = '{0, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 1, 8'h10, 0, 16'h0000, 0};
        vecs[9]  = '{0, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 1, 8'h11, 0, 16'h0000, 0};
        vecs[10] = '{0, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 1, 8'h12, 1, 16'h1111, 0};
        vecs[11] = '{0, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 1, 8'h13, 1, 16'h2222, 0};
        vecs[12] = '{0, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 8'h00, 1, 16'h3333, 0};
        vecs[13] = '{0, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 8'h00, 1, 16'h4444, 1};
        vecs[14] = '{0, 0, 8'h00, 0, 0, 16'h0000, 1, 1, 0, 1, 0, 0, 8'h00, 0, 16'h0000, 0};
        vecs[15] = '{0, 0, 8'h00, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 8'h00, 0, 16'h0000, 0};

        // reset values while rst is held
        @(posedge clk); #2;
        chk("rst.cmd_ready", cmd_ready, 0);
        chk("rst.wdata_ready", wdata_ready, 0);
        chk("rst.rdata_valid", rdata_valid, 0);
        chk("rst.rdata_last", rdata_last, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.we", ram.we, 0);
        chk("rst.din", ram.din, 0);
        chk("rst.addr", ram.addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst.cmd_ready_after", cmd_ready, 1);

        // 4-beat write at 0x10 then read back with rdata_ready high, cycle by cycle
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            cmd_valid   = vecs[i].cv;
            cmd_write   = vecs[i].cw;
            cmd_addr    = vecs[i].ca;
            cmd_len     = vecs[i].cl;
            wdata_valid = vecs[i].wv;
            wdata       = vecs[i].wd;
            rdata_ready = vecs[i].rr;
            #1;
            chk($sformatf("v%0d.cmd_ready", i), cmd_ready, vecs[i].e_cr);
            chk($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d.done", i), done, vecs[i].e_done);
            chk($sformatf("v%0d.we", i), ram.we, vecs[i].e_we);
            chk($sformatf("v%0d.err", i), err, 0);
            chk($sformatf("v%0d.rdata_valid", i), rdata_valid, vecs[i].e_rv);
            chk($sformatf("v%0d.rdata_last", i), rdata_last, vecs[i].e_last);
            if (vecs[i].chk_a)
                chk($sformatf("v%0d.addr", i), ram.addr, vecs[i].e_addr);
            if (vecs[i].e_rv)
                chk($sformatf("v%0d.rdata", i), rdata, vecs[i].e_rd);
            if (vecs[i].e_we)
                chk($sformatf("v%0d.din", i), ram.din, vecs[i].wd);
        end
        model[8'h10] = 16'h1111;
        model[8'h11] = 16'h2222;
        model[8'h12] = 16'h3333;
        model[8'h13] = 16'h4444;

        // 8 beats read back with rdata_ready toggling
        wr_burst(8'h40, 8, 16'hA000);
        rd_burst(8'h40, 8, 1);

`ifdef RAM_CTRL_BOUND_CHK_EN
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hFE; cmd_len = 8'd2;
        wdata_valid = 1'b1; wdata = 16'hBAD0;
        #1;
        chk("bound.cmd_ready", cmd_ready, 1);
        chk("bound.we0", ram.we, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #1;
        chk("bound.err", err, 1);
        chk("bound.busy", busy, 0);
        chk("bound.we1", ram.we, 0);
        chk("bound.wdata_ready", wdata_ready, 0);
        @(posedge clk); #1;
        wdata_valid = 1'b0;
        #1;
        chk("bound.err_pulse", err, 0);
        chk("bound.done", done, 0);
        chk("bound.busy2", busy, 0);
`else
        // address wrap at the top of the RAM
        wr_burst(8'hFE, 3, 16'h7000);
        rd_burst(8'hFE, 3, 1);
`endif

        // reset in the middle of a 16-beat write
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h80; cmd_len = 8'd15;
        #1;
        chk("mid.cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0; wdata_valid = 1'b1; wdata = 16'hC000 + 16'(i);
            model[8'h80 + 8'(i)] = 16'hC000 + 16'(i);
        end
        @(posedge clk); #1;
        rst = 1'b1; wdata = 16'hDEAD;
        #1;
        chk("mid.we", ram.we, 0);
        chk("mid.busy", busy, 0);
        chk("mid.cmd_ready", cmd_ready, 0);
        chk("mid.wdata_ready", wdata_ready, 0);
        chk("mid.done", done, 0);
        chk("mid.rdata_valid", rdata_valid, 0);
        chk("mid.addr", ram.addr, 0);
        chk("mid.din", ram.din, 0);
        @(posedge clk); #1;
        chk("mid.no_write_85", mem[8'h85], model[8'h85]);
        rst = 1'b0; wdata_valid = 1'b0;
        #1;
        chk("mid.cmd_ready_after", cmd_ready, 1);
        wr_burst(8'h20, 2, 16'h5A00);
        rd_burst(8'h80, 6, 0);

        // full-length burst: 2^LWID beats from address 0
        rd_burst(8'h00, 256, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Burst initiator for the single-port RAM interface: drives the `ram_if.ctrl` side of a memory built on `ram_if.mem`, such as one port of `ram2p`. Accepts one burst command at a time (write or read, start address, length) and streams write data into the RAM or read data out of it. Read data passes through a 2-entry buffer with valid/ready backpressure, so the fixed 1-cycle RAM read latency never drops a beat.

## Interface
Parameters:
- DEPTH, 256, number of RAM words; address wrap point
- AWID, 8, address width
- DWID, 16, data width
- LWID, 8, burst length field width; burst = cmd_len+1 beats (1..2^LWID)

Ports:
- Clocking and reset (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.
- clk  in  1  single clock; also the clock of the attached `ram_if`
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  AWID  start address, < DEPTH
- cmd_len  in  LWID  beats minus one
- wdata_valid  in  1  write beat offered
- wdata_ready  out  1  write beat accepted
- wdata  in  DWID  write beat data
- rdata_valid  out  1  read beat available
- rdata_ready  in  1  consumer accepts read beat
- rdata  out  DWID  read beat data
- rdata_last  out  1  marks final beat of read burst
- busy  out  1  burst in progress (state != IDLE)
- done  out  1  one-cycle pulse at burst completion
- err  out  1  one-cycle pulse on rejected command (only with RAM_CTRL_BOUND_CHK_EN; tied 0 otherwise)
- ram  ram_if.ctrl  —  drives ram.we, ram.din, ram.addr; samples ram.dout

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: latch addr, remaining beats = cmd_len+1, go to WRITE or READ.
- WRITE: wdata_ready=1. ram.we = wdata_valid, ram.din = wdata, ram.addr = current addr (combinational pass-through). Each accepted beat advances addr and decrements count. After the last beat: done pulse next cycle, return to IDLE.
- READ: issue a read (present ram.addr, we=0) when fifo_count + inflight - pop < 2, where pop = rdata_valid&&rdata_ready. Each issue advances addr. After the last issue go to DRAIN.
- DRAIN: wait until the buffer is empty and nothing is in flight. Then done pulse, return to IDLE.
- ram.dout is pushed into the 2-entry buffer the cycle after each issue. rdata_last is set on the entry carrying the final beat.
- Address increment: addr = (addr == DEPTH-1) ? 0 : addr+1. The wrap also applies when DEPTH is not a power of two.
- Count arithmetic is LWID+1 bits wide, so a burst of 2^LWID beats is exact.
- ram.we is 0 in every state except WRITE with wdata_valid.
- Reset values: cmd_ready=0 while rst is asserted and 1 in IDLE afterwards. wdata_ready, rdata_valid, rdata_last, busy, done, err, ram.we are 0. rdata, ram.din, ram.addr are 0. The buffer is emptied.
- Reset mid-burst: abort immediately; no further RAM writes; buffered read data is discarded.

## Timing
- Command accepted in cycle 0; first RAM access in cycle 1.
- Write: one beat per cycle while wdata_valid stays high. A burst of N beats gives done in cycle N+1.
- Read: issue in cycle k, data in the buffer at the end of cycle k+1, rdata_valid in cycle k+2.
- With rdata_ready held high: one beat per cycle, first rdata_valid in cycle 3, done the cycle after the last pop.
- Backpressure: issue stalls so the buffer never overflows; data is held stable while rdata_valid&&!rdata_ready.
- Back-to-back commands: at least one IDLE cycle between bursts.

## Configuration
- RAM_CTRL_BOUND_CHK_EN defined: a command with cmd_addr + cmd_len + 1 > DEPTH is rejected in IDLE. The command is consumed, err pulses for one cycle, no RAM access is made and done does not pulse.
- RAM_CTRL_BOUND_CHK_EN undefined: all commands are accepted, addresses wrap, and err is tied 0.

## Structure
- Package `ram_ctrl_pkg`: FSM state enum `ram_ctrl_state_e` and the command struct `ram_ctrl_cmd_t` {write, addr, len}.
- Sub-module `ram_ctrl_rbuf`: 2-entry synchronous FIFO {data, last} with count output, async-reset.

## Test plan
- Write 4 beats 0x1111..0x4444 at addr 0x10 -> ram.we high for 4 cycles at addresses 0x10..0x13; done in cycle 5.
- Read back the same 4 beats with rdata_ready=1 -> rdata 0x1111..0x4444 on consecutive cycles starting cycle 3; rdata_last on 0x4444; done one cycle later.
- Read 8 beats with rdata_ready toggling 1/0 -> no beat lost or duplicated; buffer count never exceeds 2; data stable during stalls.
- Write 3 beats at addr DEPTH-2 -> addresses DEPTH-2, DEPTH-1, 0. With RAM_CTRL_BOUND_CHK_EN instead: err pulse, no we, busy stays 0.
- Assert rst in the middle of a 16-beat write -> ram.we=0 immediately; all outputs at reset values; next command executes normally.
- cmd_len=2^LWID-1 read -> exactly 2^LWID beats returned with a single rdata_last.
